// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions.
// Contents:
//   hz_state_e      - hazard sequencer FSM states
//   OPC_*           - RV32 major opcode constants
//   opcode_uses_rs2 - 1 when the opcode reads rs2 (R-type, store, branch)
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } hz_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

  function automatic logic opcode_uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_RTYPE) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when the load in ID/EX writes a register that the instruction in
// IF/ID reads. x0 never creates a hazard; rs2 is considered only for
// opcodes that actually read it.
// Ports:
//   idex_memread, idex_rd         - load flag and destination in ID/EX
//   ifid_rs1, ifid_rs2, ifid_opcode - source fields of the IF/ID instruction
//   load_use                      - hazard present this cycle
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic [6:0] ifid_opcode,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = (idex_rd == ifid_rs1);
  assign rs2_hit  = (idex_rd == ifid_rs2) && opcode_uses_rs2(ifid_opcode);
  assign load_use = idex_memread && (idex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: branch flush, data-memory wait/timeout and
// load-use stall control for a 5-stage pipeline.
// Outputs are combinational from the FSM state plus current inputs, so
// stall and flush decisions take effect in the cycle they are detected.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_count and
// flush_count performance counters (ports and registers).
// Ports:
//   clk, reset (async, active-high)
//   ifid_rs1/rs2/opcode, idex_rd/memread   - hazard detection inputs
//   exmem_branch/zero/memread/memwrite     - EX/MEM control
//   dmem_ready                             - data memory handshake
//   pc_write, ifid_write                   - 0 stalls PC / IF-ID
//   ctrl_stall                             - insert bubble into ID/EX
//   ifid_flush, idex_flush                 - squash on taken branch
//   pipe_hold                              - freeze pipeline on memory wait
//   dmem_req, mem_timeout                  - memory request / abort pulse
//   stall_count, flush_count               - perf counters (optional)
module hazard_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic [6:0]  ifid_opcode,
  input  logic [4:0]  idex_rd,
  input  logic        idex_memread,
  input  logic        exmem_branch,
  input  logic        exmem_zero,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ctrl_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic        dmem_req,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  // Wide enough to hold MAX_MEM_WAIT itself; the counter never passes it.
  localparam int CNT_W = (MAX_MEM_WAIT < 2) ? 1 : $clog2(MAX_MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_MEM_WAIT);
  localparam logic [CNT_W-1:0] WAIT_ONE = CNT_W'(1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic taken;
  logic mem_access;
  logic load_use;

  assign taken      = exmem_branch & exmem_zero;
  assign mem_access = exmem_memread | exmem_memwrite;

  load_use_detect u_load_use_detect (
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_opcode  (ifid_opcode),
    .load_use     (load_use)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ctrl_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_hold   = 1'b0;
    dmem_req    = 1'b0;
    mem_timeout = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = ST_FLUSH;
        end else if (mem_access) begin
          dmem_req = 1'b1;
          // Memory not ready in the request cycle: hold immediately and
          // count the following cycles in MEM_WAIT.
          if (!dmem_ready) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            wait_cnt_d = WAIT_ONE;
            state_d    = ST_MEM_WAIT;
          end
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ctrl_stall = 1'b1;
          state_d    = ST_LOAD_STALL;
        end
      end

      // One cycle of normal outputs; load-use is deliberately not re-examined
      // so each hazard yields exactly one bubble.
      ST_LOAD_STALL, ST_FLUSH: begin
        state_d = ST_RUN;
      end

      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          dmem_req = 1'b1;
          state_d  = ST_RUN;
        end else begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          if (wait_cnt_q == WAIT_MAX) begin
            // Abort: drop the request and report it for one cycle.
            mem_timeout = 1'b1;
            state_d     = ST_RUN;
          end else begin
            dmem_req   = 1'b1;
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Outputs are Mealy on live inputs, so reset must also force them to the
    // idle pattern directly; this drops dmem_req asynchronously.
    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ctrl_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      pipe_hold   = 1'b0;
      dmem_req    = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_flush) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer (MAX_MEM_WAIT = 4).
// The stimulus process drives one input vector per cycle just after the
// rising edge and queues the hand-computed output pattern for that cycle;
// the monitor pops one entry at every falling edge and compares.
// Output pattern bit order:
//   {pc_write, ifid_write, ctrl_stall, ifid_flush, idex_flush, pipe_hold,
//    dmem_req, mem_timeout}
module tb_hazard_sequencer;
  import pipeline_ctrl_pkg::*;

  localparam int MAX_WAIT = 4;

  localparam logic [7:0] O_NORM    = 8'b1100_0000;
  localparam logic [7:0] O_STALL   = 8'b0010_0000;
  localparam logic [7:0] O_FLUSH   = 8'b1101_1000;
  localparam logic [7:0] O_MEMOK   = 8'b1100_0010;
  localparam logic [7:0] O_MEMWAIT = 8'b0000_0110;
  localparam logic [7:0] O_TIMEOUT = 8'b0000_0101;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic [6:0] ifid_opcode;
  logic       idex_memread, exmem_branch, exmem_zero;
  logic       exmem_memread, exmem_memwrite, dmem_ready;
  logic       pc_write, ifid_write, ctrl_stall, ifid_flush, idex_flush;
  logic       pipe_hold, dmem_req, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
`endif

  always #5 clk = ~clk;

  hazard_sequencer #(.MAX_MEM_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2),
    .ifid_opcode    (ifid_opcode),
    .idex_rd        (idex_rd),
    .idex_memread   (idex_memread),
    .exmem_branch   (exmem_branch),
    .exmem_zero     (exmem_zero),
    .exmem_memread  (exmem_memread),
    .exmem_memwrite (exmem_memwrite),
    .dmem_ready     (dmem_ready),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ctrl_stall     (ctrl_stall),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .pipe_hold      (pipe_hold),
    .dmem_req       (dmem_req),
    .mem_timeout    (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_count    (stall_count),
    .flush_count    (flush_count)
`endif
  );

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] opc;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       zr;
    logic       mrd;
    logic       mwr;
    logic       rdy;
  } stim_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] outs;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [6:0] opc, input logic [4:0] rd,
                               input logic ld, input logic br, input logic zr,
                               input logic mrd, input logic mwr, input logic rdy);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.opc = opc; s.rd = rd; s.ld = ld;
    s.br = br; s.zr = zr; s.mrd = mrd; s.mwr = mwr; s.rdy = rdy;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    ifid_rs1       = s.rs1;
    ifid_rs2       = s.rs2;
    ifid_opcode    = s.opc;
    idex_rd        = s.rd;
    idex_memread   = s.ld;
    exmem_branch   = s.br;
    exmem_zero     = s.zr;
    exmem_memread  = s.mrd;
    exmem_memwrite = s.mwr;
    dmem_ready     = s.rdy;
  endtask

  task automatic step(input string name, input stim_t s, input logic [7:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(s);
    x.name = name; x.rst = 1'b0; x.outs = e;
    sb_q.push_back(x);
  endtask

  // Monitor: one queued expectation per falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, {24'd0, pc_write, ifid_write, ctrl_stall, ifid_flush,
                       idex_flush, pipe_hold, dmem_req, mem_timeout},
              {24'd0, e.outs});
`ifdef HAZARD_PERF_CNT_EN
        if (e.rst) begin
          m_stall = 32'd0;
          m_flush = 32'd0;
        end
        check({e.name, "_stall_cnt"}, stall_count, m_stall);
        check({e.name, "_flush_cnt"}, flush_count, m_flush);
        if (!e.rst) begin
          if (!e.outs[7]) m_stall = m_stall + 32'd1;
          if (e.outs[4])  m_flush = m_flush + 32'd1;
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    stim_t idle, lu, x0, rs2_i, rs2_s, taken_lu, not_taken, taken_mem;
    stim_t memw_ok, mem_lu_ok, mem_wait, mem_rdy;
    exp_t  x;

    idle      = mk(5'd0, 5'd0, OPC_ITYPE,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lu        = mk(5'd5, 5'd1, OPC_RTYPE,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    x0        = mk(5'd0, 5'd0, OPC_RTYPE,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rs2_i     = mk(5'd3, 5'd7, OPC_ITYPE,  5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rs2_s     = mk(5'd3, 5'd7, OPC_STORE,  5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    taken_lu  = mk(5'd5, 5'd1, OPC_RTYPE,  5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    not_taken = mk(5'd0, 5'd0, OPC_BRANCH, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    taken_mem = mk(5'd0, 5'd0, OPC_ITYPE,  5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    memw_ok   = mk(5'd0, 5'd0, OPC_ITYPE,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    mem_lu_ok = mk(5'd5, 5'd1, OPC_RTYPE,  5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    mem_wait  = mk(5'd0, 5'd0, OPC_ITYPE,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem_rdy   = mk(5'd0, 5'd0, OPC_ITYPE,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset with a pending memory access: outputs must still be idle.
    reset = 1'b1;
    apply(mem_wait);
    x.name = "reset"; x.rst = 1'b1; x.outs = O_NORM;
    sb_q.push_back(x);
    repeat (2) @(posedge clk);

    step("idle",          idle,      O_NORM);
    // Load-use on rs1: one stall cycle then exactly one bubble.
    step("lu_stall",      lu,        O_STALL);
    step("lu_bubble_end", lu,        O_NORM);
    step("lu_clear",      idle,      O_NORM);
    // x0 never hazards; rs2 ignored for I-type, honoured for store.
    step("x0_no_stall",   x0,        O_NORM);
    step("rs2_itype",     rs2_i,     O_NORM);
    step("rs2_store",     rs2_s,     O_STALL);
    step("rs2_store_end", idle,      O_NORM);
    // Taken branch beats load-use; FLUSH ignores the hazard next cycle.
    step("flush_prio",    taken_lu,  O_FLUSH);
    step("flush_suppr",   lu,        O_NORM);
    step("not_taken",     not_taken, O_NORM);
    // Taken branch beats a memory access.
    step("flush_vs_mem",  taken_mem, O_FLUSH);
    step("flush_end",     idle,      O_NORM);
    // Memory ready in the request cycle: no stall; memory beats load-use.
    step("mem_ok",        memw_ok,   O_MEMOK);
    step("mem_over_lu",   mem_lu_ok, O_MEMOK);
    step("run_after_mem", lu,        O_STALL);
    step("run_after_lu",  idle,      O_NORM);
    // Ready low for 3 cycles, released on the ready cycle.
    step("mw_req",        mem_wait,  O_MEMWAIT);
    step("mw_wait1",      mem_wait,  O_MEMWAIT);
    step("mw_wait2",      mem_wait,  O_MEMWAIT);
    step("mw_ready",      mem_rdy,   O_MEMOK);
    step("mw_done",       idle,      O_NORM);
    // Never ready: timeout on the 4th wait cycle, then back in RUN.
    step("to_req",        mem_wait,  O_MEMWAIT);
    step("to_wait1",      mem_wait,  O_MEMWAIT);
    step("to_wait2",      mem_wait,  O_MEMWAIT);
    step("to_wait3",      mem_wait,  O_MEMWAIT);
    step("to_timeout",    mem_wait,  O_TIMEOUT);
    step("to_run_lu",     lu,        O_STALL);
    step("to_run_end",    idle,      O_NORM);
    // Reset mid-wait: request drops before the next edge, no timeout.
    step("rw_req",        mem_wait,  O_MEMWAIT);
    step("rw_wait1",      mem_wait,  O_MEMWAIT);
    @(posedge clk);
    #1;
    apply(mem_wait);
    #1;
    reset = 1'b1;
    x.name = "rst_in_wait"; x.rst = 1'b1; x.outs = O_NORM;
    sb_q.push_back(x);
    step("post_rst_lu",   lu,        O_STALL);
    step("post_rst_end",  idle,      O_NORM);

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
